// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths and helpers for the decode hazard scoreboard
//
// Package rt_hazard_pkg
//   Default register-file address widths, source-port count and pending
//   counter width, the index of the hard-wired scalar zero register, and
//   the saturation value of a pending-write counter.
package rt_hazard_pkg;

  localparam int S_ADDR_W_DEF = 5;
  localparam int V_ADDR_W_DEF = 4;
  localparam int NUM_SRC_DEF  = 2;
  localparam int CNT_W_DEF    = 2;
  localparam int ZERO_REG     = 0;

  // Largest number of outstanding writes a CNT_W-bit counter can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_pending_counter_file.sv
// rtl/hazard_scoreboard_pending_counter_file.sv - per-register pending-write counters for one register file
//
// Module pending_counter_file
//   One CNT_W-bit counter per register. A write issued at decode increments
//   the destination count, a writeback decrements it, both together leave it
//   unchanged. Retiring a register whose count is already 0 is ignored.
//   When ZERO_EXEMPT is set, register 0 is never tracked.
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   flush             clears every counter at the next edge
//   inc_en, inc_addr  issue of a write to inc_addr
//   dec_en, dec_addr  writeback retiring a write to dec_addr
//   look_addr         NUM_LOOK packed lookup addresses
//   count_zero/one/max  per-lookup status of the addressed counter
module pending_counter_file
  import rt_hazard_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 2,
  parameter int NUM_LOOK    = 3,
  parameter bit ZERO_EXEMPT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       inc_en,
  input  logic [ADDR_W-1:0]          inc_addr,
  input  logic                       dec_en,
  input  logic [ADDR_W-1:0]          dec_addr,
  input  logic [NUM_LOOK*ADDR_W-1:0] look_addr,
  output logic [NUM_LOOK-1:0]        count_zero,
  output logic [NUM_LOOK-1:0]        count_one,
  output logic [NUM_LOOK-1:0]        count_max
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic             inc_ok;
  logic             dec_ok;

  assign inc_ok = inc_en && !(ZERO_EXEMPT && inc_addr == ADDR_W'(ZERO_REG));
  // A retire only counts against a register that actually has a write pending.
  assign dec_ok = dec_en && !(ZERO_EXEMPT && dec_addr == ADDR_W'(ZERO_REG))
                  && (cnt[dec_addr] != '0);

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst || flush) begin
        cnt[r] <= '0;
      end else if (inc_ok && inc_addr == ADDR_W'(r) && cnt[r] != CNT_MAX &&
                   !(dec_ok && dec_addr == ADDR_W'(r))) begin
        cnt[r] <= cnt[r] + 1'b1;
      end else if (dec_ok && dec_addr == ADDR_W'(r) &&
                   !(inc_ok && inc_addr == ADDR_W'(r))) begin
        cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LOOK; i++) begin : g_look
    logic [CNT_W-1:0] c;
    assign c             = cnt[look_addr[i*ADDR_W +: ADDR_W]];
    assign count_zero[i] = (c == '0);
    assign count_one[i]  = (c == CNT_W'(1));
    assign count_max[i]  = (c == CNT_MAX);
  end

  // A writeback with nothing pending means the pipeline lost track of a write.
  underflow_chk: assert property (@(posedge clk) disable iff (rst || flush)
    !(dec_en && !(ZERO_EXEMPT && dec_addr == ADDR_W'(ZERO_REG)) && cnt[dec_addr] == '0));

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage hazard scoreboard with WB bypass select
//
// Module hazard_scoreboard
//   Tracks outstanding scalar and vector writes and stalls decode while any
//   used source has a pending producer that is not being written back this
//   cycle as its only outstanding write. Also stalls when the destination
//   counter is saturated. Counts stalled cycles (saturating).
// Ports
//   clk, rst, flush                  clock, sync active-high reset, flush
//   DE_valid                         decode holds a valid instruction
//   DE_S_src/_valid, DE_V_src/_valid packed source addresses and port enables
//   DE_Swb_*, DE_Vwb_*               decode destination write
//   WB_Swb_*, WB_Vwb_*               writeback this cycle
//   DE_stall                         hold decode
//   DE_S_select, DE_V_select         per-port take-WB-data select
//   stall_cycles                     saturating stalled-cycle count
module hazard_scoreboard
  import rt_hazard_pkg::*;
#(
  parameter int S_ADDR_W   = S_ADDR_W_DEF,
  parameter int V_ADDR_W   = V_ADDR_W_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int S_ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         DE_valid,
  input  logic [NUM_SRC*S_ADDR_W-1:0]  DE_S_src,
  input  logic [NUM_SRC-1:0]           DE_S_src_valid,
  input  logic [NUM_SRC*V_ADDR_W-1:0]  DE_V_src,
  input  logic [NUM_SRC-1:0]           DE_V_src_valid,
  input  logic                         DE_Swb_en,
  input  logic [S_ADDR_W-1:0]          DE_Swb_address,
  input  logic                         DE_Vwb_en,
  input  logic [V_ADDR_W-1:0]          DE_Vwb_address,
  input  logic                         WB_Swb_en,
  input  logic [S_ADDR_W-1:0]          WB_Swb_address,
  input  logic                         WB_Vwb_en,
  input  logic [V_ADDR_W-1:0]          WB_Vwb_address,
  output logic                         DE_stall,
  output logic [NUM_SRC-1:0]           DE_S_select,
  output logic [NUM_SRC-1:0]           DE_V_select,
  output logic [31:0]                  stall_cycles
);

  localparam bit S_ZERO = (S_ZERO_REG != 0);

  // Lookup slots 0..NUM_SRC-1 are the sources, slot NUM_SRC is the destination.
  logic [NUM_SRC:0] s_zero, s_one, s_max;
  logic [NUM_SRC:0] v_zero, v_one, v_max;
  logic [NUM_SRC-1:0] s_haz, v_haz;
  logic s_ovf, v_ovf, issue;
  logic status_unused;

  pending_counter_file #(
    .ADDR_W(S_ADDR_W), .CNT_W(CNT_W), .NUM_LOOK(NUM_SRC + 1), .ZERO_EXEMPT(S_ZERO)
  ) u_s_cnt (
    .clk(clk), .rst(rst), .flush(flush),
    .inc_en(issue && DE_Swb_en), .inc_addr(DE_Swb_address),
    .dec_en(WB_Swb_en), .dec_addr(WB_Swb_address),
    .look_addr({DE_Swb_address, DE_S_src}),
    .count_zero(s_zero), .count_one(s_one), .count_max(s_max)
  );

  pending_counter_file #(
    .ADDR_W(V_ADDR_W), .CNT_W(CNT_W), .NUM_LOOK(NUM_SRC + 1), .ZERO_EXEMPT(1'b0)
  ) u_v_cnt (
    .clk(clk), .rst(rst), .flush(flush),
    .inc_en(issue && DE_Vwb_en), .inc_addr(DE_Vwb_address),
    .dec_en(WB_Vwb_en), .dec_addr(WB_Vwb_address),
    .look_addr({DE_Vwb_address, DE_V_src}),
    .count_zero(v_zero), .count_one(v_one), .count_max(v_max)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic s_is_zero;
    assign s_is_zero = S_ZERO && (DE_S_src[i*S_ADDR_W +: S_ADDR_W] == S_ADDR_W'(ZERO_REG));

    assign DE_S_select[i] = DE_S_src_valid[i] && WB_Swb_en && !s_is_zero &&
                            (WB_Swb_address == DE_S_src[i*S_ADDR_W +: S_ADDR_W]);
    assign DE_V_select[i] = DE_V_src_valid[i] && WB_Vwb_en &&
                            (WB_Vwb_address == DE_V_src[i*V_ADDR_W +: V_ADDR_W]);

    // A single pending write being retired right now is covered by the bypass;
    // with two or more pending, the younger one is still in flight.
    assign s_haz[i] = DE_S_src_valid[i] && !s_is_zero && !s_zero[i] &&
                      !(s_one[i] && DE_S_select[i]);
    assign v_haz[i] = DE_V_src_valid[i] && !v_zero[i] &&
                      !(v_one[i] && DE_V_select[i]);
  end

  assign s_ovf = DE_Swb_en && s_max[NUM_SRC] &&
                 !(S_ZERO && DE_Swb_address == S_ADDR_W'(ZERO_REG));
  assign v_ovf = DE_Vwb_en && v_max[NUM_SRC];

  assign DE_stall = DE_valid && !flush && ((|s_haz) || (|v_haz) || s_ovf || v_ovf);
  assign issue    = DE_valid && !DE_stall && !flush;

  assign status_unused = ^{s_max[NUM_SRC-1:0], s_zero[NUM_SRC], s_one[NUM_SRC],
                           v_max[NUM_SRC-1:0], v_zero[NUM_SRC], v_one[NUM_SRC]};

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (DE_stall && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk, rst, flush, DE_valid;
  logic [9:0]  DE_S_src;
  logic [1:0]  DE_S_src_valid;
  logic [7:0]  DE_V_src;
  logic [1:0]  DE_V_src_valid;
  logic        DE_Swb_en, DE_Vwb_en, WB_Swb_en, WB_Vwb_en;
  logic [4:0]  DE_Swb_address, WB_Swb_address;
  logic [3:0]  DE_Vwb_address, WB_Vwb_address;
  logic        DE_stall;
  logic [1:0]  DE_S_select, DE_V_select;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .DE_valid(DE_valid),
    .DE_S_src(DE_S_src), .DE_S_src_valid(DE_S_src_valid),
    .DE_V_src(DE_V_src), .DE_V_src_valid(DE_V_src_valid),
    .DE_Swb_en(DE_Swb_en), .DE_Swb_address(DE_Swb_address),
    .DE_Vwb_en(DE_Vwb_en), .DE_Vwb_address(DE_Vwb_address),
    .WB_Swb_en(WB_Swb_en), .WB_Swb_address(WB_Swb_address),
    .WB_Vwb_en(WB_Vwb_en), .WB_Vwb_address(WB_Vwb_address),
    .DE_stall(DE_stall), .DE_S_select(DE_S_select), .DE_V_select(DE_V_select),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  ssel;
    logic [1:0]  vsel;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  exp_t        m;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_sc;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is consumed mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk({m.name, ".stall"}, 32'(DE_stall), 32'(m.stall));
      chk({m.name, ".s_sel"}, 32'(DE_S_select), 32'(m.ssel));
      chk({m.name, ".v_sel"}, 32'(DE_V_select), 32'(m.vsel));
      chk({m.name, ".stall_cycles"}, stall_cycles, m.sc);
    end
  end

  task automatic idle();
    flush = 0; DE_valid = 0;
    DE_S_src = '0; DE_S_src_valid = '0; DE_V_src = '0; DE_V_src_valid = '0;
    DE_Swb_en = 0; DE_Swb_address = '0; DE_Vwb_en = 0; DE_Vwb_address = '0;
    WB_Swb_en = 0; WB_Swb_address = '0; WB_Vwb_en = 0; WB_Vwb_address = '0;
  endtask

  task automatic src_s(input int p, input logic [4:0] a);
    DE_S_src[p*5 +: 5] = a; DE_S_src_valid[p] = 1'b1;
  endtask

  task automatic src_v(input int p, input logic [3:0] a);
    DE_V_src[p*4 +: 4] = a; DE_V_src_valid[p] = 1'b1;
  endtask

  task automatic iss_s(input logic [4:0] a);
    DE_valid = 1; DE_Swb_en = 1; DE_Swb_address = a;
  endtask

  task automatic iss_v(input logic [3:0] a);
    DE_valid = 1; DE_Vwb_en = 1; DE_Vwb_address = a;
  endtask

  task automatic wb_s(input logic [4:0] a);
    WB_Swb_en = 1; WB_Swb_address = a;
  endtask

  task automatic wb_v(input logic [3:0] a);
    WB_Vwb_en = 1; WB_Vwb_address = a;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string name, input logic st, input logic [1:0] ss, input logic [1:0] vs);
    exp_t e;
    e.name = name; e.stall = st; e.ssel = ss; e.vsel = vs; e.sc = exp_sc;
    q.push_back(e);
    if (st) exp_sc = exp_sc + 32'd1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    @(posedge clk); #1;
    rst = 0; exp_sc = '0;
  endtask

  initial begin
    clk = 0; exp_sc = '0;
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;

    cyc("reset_idle", 0, 2'b00, 2'b00);

    // Single pending scalar write, then bypass on its writeback.
    iss_s(5);                          cyc("s5_issue", 0, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 5);         cyc("s5_wait0", 1, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 5);         cyc("s5_wait1", 1, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 5); wb_s(5); cyc("s5_bypass", 0, 2'b01, 2'b00);
    DE_valid = 1; src_s(0, 5);         cyc("s5_cleared", 0, 2'b00, 2'b00);

    // Two pending writes to V3: first retire still stalls.
    iss_v(3);                          cyc("v3_issue0", 0, 2'b00, 2'b00);
    iss_v(3);                          cyc("v3_issue1", 0, 2'b00, 2'b00);
    DE_valid = 1; src_v(1, 3); wb_v(3); cyc("v3_retire0", 1, 2'b00, 2'b10);
    DE_valid = 1; src_v(1, 3); wb_v(3); cyc("v3_retire1", 0, 2'b00, 2'b10);

    // Saturation of V7 at 3 outstanding.
    iss_v(7);                          cyc("v7_issue1", 0, 2'b00, 2'b00);
    iss_v(7);                          cyc("v7_issue2", 0, 2'b00, 2'b00);
    iss_v(7);                          cyc("v7_issue3", 0, 2'b00, 2'b00);
    iss_v(7);                          cyc("v7_ovf0", 1, 2'b00, 2'b00);
    iss_v(7);                          cyc("v7_ovf1", 1, 2'b00, 2'b00);
    wb_v(7);                           cyc("v7_retire", 0, 2'b00, 2'b00);
    iss_v(7);                          cyc("v7_reissue", 0, 2'b00, 2'b00);

    // Issue and retire of S9 in the same cycle keeps its count at 1.
    iss_s(9);                          cyc("s9_issue", 0, 2'b00, 2'b00);
    iss_s(9); wb_s(9);                 cyc("s9_iss_ret", 0, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 9);         cyc("s9_still", 1, 2'b00, 2'b00);

    // Flush with S2/V1 pending; the write to S4 in the flush cycle is dropped.
    iss_s(2); DE_Vwb_en = 1; DE_Vwb_address = 1; cyc("s2v1_issue", 0, 2'b00, 2'b00);
    flush = 1; iss_s(4); src_s(0, 2); src_v(0, 1); cyc("flush", 0, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 2); src_s(1, 4); src_v(0, 1); src_v(1, 7);
                                       cyc("post_flush", 0, 2'b00, 2'b00);

    // Zero register is never tracked, stalled or bypassed.
    iss_s(0); src_s(0, 0); wb_s(0);    cyc("s0_wb", 0, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 0);         cyc("s0_src", 0, 2'b00, 2'b00);

    // Stall-cycle counter over a 3-cycle stall, then reset.
    do_reset();
    iss_s(12);                         cyc("s12_issue", 0, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 12);        cyc("s12_stall0", 1, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 12);        cyc("s12_stall1", 1, 2'b00, 2'b00);
    DE_valid = 1; src_s(0, 12);        cyc("s12_stall2", 1, 2'b00, 2'b00);
    chk("stall_count_model", exp_sc, 32'd3);
                                       cyc("count3", 0, 2'b00, 2'b00);
    do_reset();
    DE_valid = 1; src_s(0, 12);        cyc("post_rst", 0, 2'b00, 2'b00);
                                       cyc("final_idle", 0, 2'b00, 2'b00);

    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage hazard unit for the RT core. It generalises fixed-distance load/reduce stall detection to any number of in-flight multi-cycle writes.
- Keeps a per-register pending-write counter for the scalar and vector files.
- Stalls decode while any source operand has an outstanding producer.
- Drives a WB-bypass select per source port.
- Supports flush and a saturating stall-cycle performance counter.

Parameters:
- S_ADDR_W, 5, scalar register address width (2**S_ADDR_W registers)
- V_ADDR_W, 4, vector register address width
- NUM_SRC, 2, source ports per file checked each decode
- CNT_W, 2, pending-write counter width per register (max 2**CNT_W-1 outstanding)
- S_ZERO_REG, 1, when 1 scalar register 0 is never tracked, never stalls, never bypassed

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; clears all pending counts
- DE_valid  in  1  decode holds a valid instruction
- DE_S_src  in  NUM_SRC*S_ADDR_W  scalar source addresses, port i at [i*S_ADDR_W +: S_ADDR_W]
- DE_S_src_valid  in  NUM_SRC  scalar source port used
- DE_V_src  in  NUM_SRC*V_ADDR_W  vector source addresses
- DE_V_src_valid  in  NUM_SRC  vector source port used
- DE_Swb_en  in  1  instruction writes a scalar register
- DE_Swb_address  in  S_ADDR_W  scalar destination
- DE_Vwb_en  in  1  instruction writes a vector register
- DE_Vwb_address  in  V_ADDR_W  vector destination
- WB_Swb_en  in  1  scalar writeback this cycle
- WB_Swb_address  in  S_ADDR_W  scalar writeback address
- WB_Vwb_en  in  1  vector writeback this cycle
- WB_Vwb_address  in  V_ADDR_W  vector writeback address
- DE_stall  out  1  hold decode and insert bubble
- DE_S_select  out  NUM_SRC  1 = take WB scalar data for port i
- DE_V_select  out  NUM_SRC  1 = take WB vector data for port i
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (rst=1 at clk edge):
  - all counters = 0 and stall_cycles = 0.
  - DE_stall and selects are combinational and read 0 once counters are 0 and the inputs are idle.
- Issue: issue = DE_valid & ~DE_stall & ~flush.
  - On issue with DE_Swb_en, cnt_S[DE_Swb_address] increments.
  - Same for the vector file.
- Retire: WB_Swb_en decrements cnt_S[WB_Swb_address]. Same for the vector file.
- Same register issued and retired in one cycle: count unchanged.
- Retire of a count-0 register is ignored (no underflow). Verification flags it as an assertion error.
- Zero register (S_ZERO_REG=1): issue/retire to scalar 0 never changes state; sources at 0 never stall or select.
- Select, per port i (combinational): DE_S_select[i] = src_valid[i] & WB_Swb_en & (WB_Swb_address == src[i]). Same for the vector file.
- Hazard, per valid source:
  - Hazard when count != 0, except when count == 1 and the matching WB is this cycle; in that case the value is bypassed.
  - Count >= 2 with a matching WB still stalls, because a younger write is outstanding.
- Overflow: stall when the destination count is 2**CNT_W-1. This check does not apply to the zero register.
- DE_stall = DE_valid & ~flush & (any hazard | any overflow).
- Flush: all counters = 0 next cycle, and DE_stall = 0 this cycle.
  - WB in the flush cycle is discarded; flush takes priority over issue and retire.
- stall_cycles increments each cycle DE_stall = 1 and saturates at 32'hFFFF_FFFF. Cleared only by rst.
- Latency: state updates at the clk edge; stall and select are same-cycle combinational from the inputs and current state.
- Reset mid-operation: all pending state is dropped; rst has priority over flush and everything else.

Decomposition:
- Package rt_hazard_pkg: default widths, the counter max value function, and the zero-register constant.
- One sub-module, pending_counter_file, parametrised by ADDR_W and CNT_W and instantiated once per file. It contains:
  - the counter array
  - inc/dec/flush logic
  - a per-port combinational status lookup (count_zero, count_one, count_max)
- The top level holds the select/stall combine and stall_cycles.

Test Plan:
- Issue DE_Swb_en to S5, then DE_S_src[0]=5 valid with no WB -> DE_stall=1 each cycle. Next cycle WB_Swb_en with S5 -> DE_stall=0, DE_S_select[0]=1, cnt_S[5]=0 after the edge.
- Two issues to V3 back-to-back, then a source at V3 with WB of V3 in the first retire cycle -> stall held (count 2). Second retire -> DE_stall=0, DE_V_select=1.
- Issue to V7 four times with CNT_W=2 -> the third issue succeeds (count 3). The fourth attempt gives DE_stall=1 and the count stays 3 until a retire.
- Same cycle issue to S9 and WB to S9 with count 1 -> count stays 1. A source S9 in the next cycle with no WB stalls.
- Pending on S2 and V1, assert flush -> DE_stall=0 that cycle, counts 0 next cycle, no stall on re-read. Issue in the flush cycle is not recorded.
- Source S0 with S_ZERO_REG=1 and WB to S0 -> DE_S_select=0 and DE_stall=0. Hold a stall for 3 cycles -> stall_cycles=3. Assert rst -> stall_cycles=0.
